pfb_input_scheduler: RTL and testbench

Round-robin scheduler that shares the single polyphase-filterbank decimator datapath between N_CH AXI-Stream input channels. It grants one channel at a time for a burst of BURST samples (one decimation frame), tags each output sample with its channel index, and registers the merged stream into the decimator's read stage. An optional watchdog flags sustained stalls. The flag feeds the same block/idle monitoring used in co-simulation.

---
 rtl/pfb_pkg.sv | 34 +++
 rtl/pfb_rr_pick.sv | 46 ++++
 rtl/pfb_input_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_pfb_input_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pfb_pkg
// Description : Shared types and constants for the polyphase-filterbank input
//               scheduler: scheduler state encoding, default channel/sample/
//               burst geometry and the ceil-log2 helper used to size the
//               channel index and beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pfb_pkg;

    localparam int c_default_n_ch   = 8;
    localparam int c_default_data_w = 16;
    localparam int c_default_burst  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    // Ceiling log2; returns 0 for a value of 1 so single-entry ranges need no bits.
    function automatic int pfb_clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pfb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : pfb_rr_pick
// Description : Combinational round-robin priority picker. Returns the first
//               asserted request at or after ptr, wrapping modulo N_CH.
// Ports       : req  - per-channel request vector
//               ptr  - highest-priority channel index this round
//               idx  - selected channel (valid when any is high)
//               any  - at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module pfb_rr_pick
    import pfb_pkg::*;
#(
    parameter int N_CH = c_default_n_ch,
    parameter int CH_W = pfb_clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    logic [2*N_CH-1:0] w_dbl;
    logic [N_CH-1:0]   w_rot;
    logic [CH_W-1:0]   w_off;

    // Rotate the request vector so ptr lands at bit 0, find the lowest set
    // bit, then add ptr back. N_CH is a power of two, so the CH_W-bit add
    // wraps naturally.
    always_comb begin
        w_dbl = {req, req} >> ptr;
        w_rot = w_dbl[N_CH-1:0];
        w_off = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k[CH_W-1:0];
            end
        end
    end

    assign idx = ptr + w_off;
    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/pfb_input_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pfb_input_scheduler
// Description : Round-robin scheduler sharing one decimator datapath between
//               N_CH AXI-Stream inputs. Each grant lasts BURST samples; the
//               merged stream is registered and tagged with the channel index.
//               Optional stall watchdog, enabled by defining the macro
//               PFB_SCHED_WATCHDOG_EN (otherwise stall is tied low).
// Ports       : clock, reset            - clock, async active-high reset
//               s_tdata/s_tvalid/s_tready - N_CH input streams
//               m_tdata/m_tuser/m_tlast/m_tvalid/m_tready - merged output
//               busy                    - high while a burst is in progress
//               stall                   - watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
module pfb_input_scheduler
    import pfb_pkg::*;
#(
    parameter  int N_CH       = c_default_n_ch,
    parameter  int DATA_W     = c_default_data_w,
    parameter  int BURST      = c_default_burst,
    parameter  int WDOG_LIMIT = 1024,
    localparam int CH_W       = pfb_clog2(N_CH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_CH*DATA_W-1:0] s_tdata,
    input  logic [N_CH-1:0]        s_tvalid,
    output logic [N_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic [CH_W-1:0]        m_tuser,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   busy,
    output logic                   stall
);

    // One spare bit so the counter can step past BURST-1 without wrapping.
    localparam int                c_bc_w      = pfb_clog2(BURST) + 1;
    localparam logic [c_bc_w-1:0] c_last_beat = c_bc_w'(BURST - 1);

    sched_state_t       r_state;
    logic [CH_W-1:0]    r_gnt;
    logic [CH_W-1:0]    r_rr_ptr;
    logic [c_bc_w-1:0]  r_beat_cnt;
    logic [DATA_W-1:0]  r_m_tdata;
    logic [CH_W-1:0]    r_m_tuser;
    logic               r_m_tlast;
    logic               r_m_tvalid;
    logic               r_busy;

    logic [DATA_W-1:0]  w_ch_data [N_CH];
    logic [N_CH-1:0]    w_ready;
    logic [CH_W-1:0]    w_pick_idx;
    logic               w_pick_any;
    logic               w_out_free;
    logic               w_gnt_valid;
    logic               w_in_hs;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_unpack
            assign w_ch_data[g] = s_tdata[g*DATA_W +: DATA_W];
        end
    endgenerate

    pfb_rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req (s_tvalid),
        .ptr (r_rr_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // The output register can take a new sample when empty or draining.
    assign w_out_free  = !r_m_tvalid || m_tready;
    assign w_gnt_valid = s_tvalid[r_gnt];
    assign w_in_hs     = (r_state == XFER) && w_gnt_valid && w_out_free;

    // Ready is offered to the granted channel regardless of its valid, so the
    // grant stays parked on it if it pauses mid-burst.
    always_comb begin
        w_ready = '0;
        if (r_state == XFER) begin
            w_ready[r_gnt] = w_out_free;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_m_tdata  <= '0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_in_hs) begin
                r_m_tdata  <= w_ch_data[r_gnt];
                r_m_tuser  <= r_gnt;
                r_m_tlast  <= (r_beat_cnt == c_last_beat);
                r_m_tvalid <= 1'b1;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt      <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= XFER;
                        r_busy     <= 1'b1;
                    end
                end
                XFER: begin
                    if (w_in_hs) begin
                        r_beat_cnt <= r_beat_cnt + c_bc_w'(1);
                        if (r_beat_cnt == c_last_beat) begin
                            r_rr_ptr <= r_gnt + CH_W'(1);
                            r_state  <= IDLE;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_tready = w_ready;
    assign m_tdata  = r_m_tdata;
    assign m_tuser  = r_m_tuser;
    assign m_tlast  = r_m_tlast;
    assign m_tvalid = r_m_tvalid;
    assign busy     = r_busy;

`ifdef PFB_SCHED_WATCHDOG_EN
    localparam int                c_wd_w   = pfb_clog2(WDOG_LIMIT + 1);
    localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(WDOG_LIMIT);

    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_stall;
    logic              w_out_hs;
    logic              w_wd_tick;

    assign w_out_hs  = r_m_tvalid && m_tready;
    // Stalled either downstream (output held) or upstream (granted channel idle).
    assign w_wd_tick = (r_m_tvalid && !m_tready) || ((r_state == XFER) && !w_gnt_valid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
            r_stall  <= 1'b0;
        end else if (w_in_hs || w_out_hs) begin
            r_wd_cnt <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_wd_tick && (r_wd_cnt != c_wd_max)) begin
                r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
            end
            if (r_wd_cnt == c_wd_max) begin
                r_stall <= 1'b1;
            end
        end
    end

    assign stall = r_stall;
`else
    assign stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pfb_input_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pfb_input_scheduler
// Description : Self-checking bench for pfb_input_scheduler. A reference
//               arbiter model predicts ready, valid and the output beat order;
//               expected beats are queued when accepted and popped as the DUT
//               emits them. A second instance covers the BURST=1 geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pfb_input_scheduler;

    localparam int N_CH   = 8;
    localparam int DATA_W = 16;
    localparam int BURST  = 4;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  u;
        logic        l;
    } beat_t;

    typedef struct {
        logic [2:0] u;
        logic       l;
        int         cyc;
    } log_t;

    logic                   clock;
    logic                   reset;
    logic [N_CH*DATA_W-1:0] s_tdata;
    logic [N_CH-1:0]        s_tvalid;
    logic [N_CH-1:0]        s_tready;
    logic [DATA_W-1:0]      m_tdata;
    logic [2:0]             m_tuser;
    logic                   m_tlast;
    logic                   m_tvalid;
    logic                   m_tready;
    logic                   busy;
    logic                   stall;

    logic [N_CH*DATA_W-1:0] s_tdata1;
    logic [N_CH-1:0]        s_tvalid1;
    logic [N_CH-1:0]        s_tready1;
    logic [DATA_W-1:0]      m_tdata1;
    logic [2:0]             m_tuser1;
    logic                   m_tlast1;
    logic                   m_tvalid1;
    logic                   m_tready1;
    logic                   busy1;
    logic                   stall1;

    int checks = 0;
    int errors = 0;

    pfb_input_scheduler #(.N_CH(N_CH), .DATA_W(DATA_W), .BURST(BURST), .WDOG_LIMIT(1024)) dut (
        .clock(clock), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .busy(busy), .stall(stall)
    );

    pfb_input_scheduler #(.N_CH(N_CH), .DATA_W(DATA_W), .BURST(1), .WDOG_LIMIT(1024)) dut1 (
        .clock(clock), .reset(reset),
        .s_tdata(s_tdata1), .s_tvalid(s_tvalid1), .s_tready(s_tready1),
        .m_tdata(m_tdata1), .m_tuser(m_tuser1), .m_tlast(m_tlast1),
        .m_tvalid(m_tvalid1), .m_tready(m_tready1),
        .busy(busy1), .stall(stall1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (BURST=4 instance) -------------------
    logic [11:0] seq [N_CH];
    logic        md_state;
    logic [2:0]  md_gnt;
    logic [2:0]  md_ptr;
    int          md_bc;
    logic        md_mv;
    int          md_hs_cnt;
    logic        md_hs;
    logic [7:0]  exp_rdy;
    beat_t       exp_q [$];
    beat_t       q1 [$];
    log_t        log_q [$];

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            s_tdata[k*DATA_W +: DATA_W]  = {1'b0, 3'(k), seq[k]};
            s_tdata1[k*DATA_W +: DATA_W] = 16'hB000 + 16'(k);
        end
    end

    // Returns {found, channel} for the first valid channel scanning from ptr.
    function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] p);
        logic [2:0] c;
        for (int off = 0; off < N_CH; off++) begin
            c = p + 3'(off);
            if (v[c]) return {1'b1, c};
        end
        return 4'b0000;
    endfunction

    assign md_hs = md_state && s_tvalid[md_gnt] && (!md_mv || m_tready);

    always_comb begin
        exp_rdy = '0;
        if (md_state) exp_rdy[md_gnt] = !md_mv || m_tready;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            md_state  <= 1'b0;
            md_gnt    <= '0;
            md_ptr    <= '0;
            md_bc     <= 0;
            md_mv     <= 1'b0;
            md_hs_cnt <= 0;
            for (int k = 0; k < N_CH; k++) seq[k] <= '0;
            exp_q.delete();
        end else begin
            if (md_hs) begin
                exp_q.push_back('{d: {1'b0, md_gnt, seq[md_gnt]}, u: md_gnt, l: (md_bc == BURST - 1)});
                seq[md_gnt] <= seq[md_gnt] + 12'd1;
                md_mv       <= 1'b1;
                md_hs_cnt   <= md_hs_cnt + 1;
                md_bc       <= md_bc + 1;
                if (md_bc == BURST - 1) begin
                    md_state <= 1'b0;
                    md_ptr   <= md_gnt + 3'd1;
                end
            end else if (m_tready) begin
                md_mv <= 1'b0;
            end
            if (!md_state && pick(s_tvalid, md_ptr)[3]) begin
                md_gnt   <= pick(s_tvalid, md_ptr)[2:0];
                md_bc    <= 0;
                md_state <= 1'b1;
            end
        end
    end

    // ---------------- monitors ---------------------------------------------
    int         cyc = 0;
    logic [7:0] allow_mask = 8'hFF;
    logic       other_rdy = 1'b0;
    beat_t      e0;
    beat_t      e1;

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            chk("s_tready", 32'(s_tready), 32'(exp_rdy));
            chk("m_tvalid", 32'(m_tvalid), 32'(md_mv));
            chk("busy", 32'(busy), 32'(md_state));
`ifndef PFB_SCHED_WATCHDOG_EN
            chk("stall_tied_low", 32'(stall), 0);
`endif
            if ((s_tready & ~allow_mask) != 8'h00) other_rdy = 1'b1;
            if (m_tvalid && m_tready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e0 = exp_q.pop_front();
                    chk("m_tdata", 32'(m_tdata), 32'(e0.d));
                    chk("m_tuser", 32'(m_tuser), 32'(e0.u));
                    chk("m_tlast", 32'(m_tlast), 32'(e0.l));
                end
                log_q.push_back('{u: m_tuser, l: m_tlast, cyc: cyc});
            end
            if (m_tvalid1 && m_tready1 && (q1.size() != 0)) begin
                e1 = q1.pop_front();
                chk("b1_m_tdata", 32'(m_tdata1), 32'(e1.d));
                chk("b1_m_tuser", 32'(m_tuser1), 32'(e1.u));
                chk("b1_m_tlast", 32'(m_tlast1), 32'(e1.l));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        log_q.delete();
        other_rdy = 1'b0;
    endtask

    task automatic wait_hs(input int n, input string tag);
        int k;
        k = 0;
        while ((md_hs_cnt < n) && (k < 50)) begin
            tick();
            k++;
        end
        chk(tag, 32'(md_hs_cnt >= n), 1);
    endtask

    int rise_at;

    initial begin
        reset     = 1'b1;
        s_tvalid  = '0;
        s_tvalid1 = '0;
        m_tready  = 1'b1;
        m_tready1 = 1'b1;
        rise_at   = -1;
        repeat (3) tick();

        // Reset state
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        chk("rst_m_tuser", 32'(m_tuser), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_b1_m_tvalid", 32'(m_tvalid1), 0);
        reset = 1'b0;

        // BURST=1: channels 0 and 1 alternate, every beat is last
        for (int i = 0; i < 6; i++)
            q1.push_back('{d: 16'hB000 + 16'(i % 2), u: 3'(i % 2), l: 1'b1});
        s_tvalid1 = 8'b0000_0011;
        repeat (20) tick();
        s_tvalid1 = '0;
        repeat (4) tick();
        chk("b1_all_beats_seen", 32'(q1.size()), 0);

        // All channels valid, continuous drain
        pulse_reset();
        s_tvalid = 8'hFF;
        repeat (50) tick();
        s_tvalid = '0;
        chk("all_beat_count", 32'(log_q.size() >= 36), 1);
        for (int i = 0; i < 36 && i < log_q.size(); i++) begin
            chk("all_user_seq", 32'(log_q[i].u), 32'((i / 4) % 8));
            chk("all_last_seq", 32'(log_q[i].l), 32'(i % 4 == 3));
        end
        if (log_q.size() >= 5) begin
            chk("all_in_burst_gap", 32'(log_q[1].cyc - log_q[0].cyc), 1);
            chk("all_bubble_gap", 32'(log_q[4].cyc - log_q[3].cyc), 2);
        end
        repeat (5) tick();

        // Only channels 2 and 5 request
        pulse_reset();
        allow_mask = 8'b0010_0100;
        s_tvalid   = 8'b0010_0100;
        repeat (30) tick();
        s_tvalid = '0;
        chk("c_beat_count", 32'(log_q.size() >= 16), 1);
        for (int i = 0; i < 16 && i < log_q.size(); i++)
            chk("c_user_seq", 32'(log_q[i].u), ((i / 4) % 2 == 1) ? 32'd5 : 32'd2);
        chk("c_no_other_ready", 32'(other_rdy), 0);
        repeat (5) tick();
        allow_mask = 8'hFF;

        // Granted channel 3 pauses after its first beat
        pulse_reset();
        s_tvalid = 8'b0000_1000;
        wait_hs(1, "d_first_beat");
        allow_mask = 8'b0000_1000;
        s_tvalid   = 8'b1111_0111;
        repeat (10) tick();
        chk("d_busy_hold", 32'(busy), 1);
        chk("d_beats_during_pause", 32'(log_q.size()), 1);
        chk("d_no_other_ready", 32'(other_rdy), 0);
        allow_mask = 8'hFF;
        s_tvalid   = 8'hFF;
        repeat (10) tick();
        s_tvalid = '0;
        chk("d_beat_count", 32'(log_q.size() >= 5), 1);
        if (log_q.size() >= 5) begin
            for (int i = 0; i < 4; i++) begin
                chk("d_user", 32'(log_q[i].u), 3);
                chk("d_last", 32'(log_q[i].l), 32'(i == 3));
            end
            chk("d_next_grant", 32'(log_q[4].u), 4);
        end
        repeat (8) tick();

        // Downstream stall for 2000 cycles
        pulse_reset();
        s_tvalid = 8'hFF;
        m_tready = 1'b1;
        wait_hs(1, "e_first_beat");
        m_tready = 1'b0;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (stall && (rise_at < 0)) rise_at = i;
        end
`ifdef PFB_SCHED_WATCHDOG_EN
        chk("e_stall_rise_window", 32'((rise_at >= 1000) && (rise_at <= 1050)), 1);
        chk("e_stall_high", 32'(stall), 1);
`else
        chk("e_stall_never", 32'(rise_at), 32'(-1));
`endif
        m_tready = 1'b1;
        tick();
        chk("e_stall_cleared", 32'(stall), 0);
        repeat (10) tick();
        s_tvalid = '0;
        repeat (10) tick();

        // Reset asserted on beat 2 of channel 6
        pulse_reset();
        s_tvalid = 8'b0100_0000;
        wait_hs(2, "f_two_beats");
        reset = 1'b1;
        #1;
        chk("f_m_tvalid", 32'(m_tvalid), 0);
        chk("f_m_tdata", 32'(m_tdata), 0);
        chk("f_m_tuser", 32'(m_tuser), 0);
        chk("f_m_tlast", 32'(m_tlast), 0);
        chk("f_busy", 32'(busy), 0);
        chk("f_stall", 32'(stall), 0);
        chk("f_s_tready", 32'(s_tready), 0);
        s_tvalid = 8'b0101_0100;
        tick();
        reset = 1'b0;
        log_q.delete();
        for (int k = 0; (k < 20) && (log_q.size() == 0); k++) tick();
        chk("f_beat_after_reset", 32'(log_q.size() != 0), 1);
        if (log_q.size() != 0) chk("f_first_grant", 32'(log_q[0].u), 2);
        s_tvalid = '0;
        repeat (10) tick();
        chk("final_queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
